// File: rtl/serial_add_seq_pkg.sv
// serial_add_seq_pkg: shared state encoding and default operand width for the bit-serial adder sequencer
package serial_add_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_seq.sv
// serial_add_seq: sequences a WIDTH-bit addition LSB-first through an external 1-bit full-adder stage
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_ci,
  input  logic             bit_sum,
  input  logic             bit_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run;
  logic             last;

  assign run    = state_q == S_RUN;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign bit_a  = run & a_q[0];
  assign bit_b  = run & b_q[0];
  assign bit_ci = run & carry_q;
  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
  assign sum    = sum_q;
  assign cout   = cout_q;

  // next state: load on accepted start, one bit per cycle in RUN, single DONE cycle back to IDLE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && start) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      sum_d   = '0;
      cnt_d   = '0;
    end else if (run) begin
      sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
      carry_d = bit_co;
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? S_DONE : S_RUN;
      cout_d  = last ? bit_co : cout_q;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  // state registers, cleared asynchronously so a reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: scoreboard bench for 8- and 16-bit sequencers, each wired to a gate-level full adder
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad = 0;

  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        ba8, bb8, bc8, busy8, done8, cout8;
  wire         bs8, bo8, x8, p8, r8;

  logic        start16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        ba16, bb16, bc16, busy16, done16, cout16;
  wire         bs16, bo16, x16, p16, r16;

  xor g80 (x8, ba8, bb8);
  xor g81 (bs8, x8, bc8);
  and g82 (p8, ba8, bb8);
  and g83 (r8, x8, bc8);
  or  g84 (bo8, p8, r8);

  xor g160 (x16, ba16, bb16);
  xor g161 (bs16, x16, bc16);
  and g162 (p16, ba16, bb16);
  and g163 (r16, x16, bc16);
  or  g164 (bo16, p16, r16);

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .bit_a(ba8), .bit_b(bb8), .bit_ci(bc8), .bit_sum(bs8), .bit_co(bo8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .bit_a(ba16), .bit_b(bb16), .bit_ci(bc16), .bit_sum(bs16), .bit_co(bo16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  int          left8 = 0;
  int          left16 = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [8:0]  e8;
  logic [16:0] e16;

  // reference acceptance model: pushes the expected result when an idle instance sees start
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      left8 = 0;
      left16 = 0;
      q8.delete();
      q16.delete();
    end else begin
      if (left8 != 0) left8--;
      else if (start8) begin
        q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
        left8 = 9;
      end
      if (left16 != 0) left16--;
      else if (start16) begin
        q16.push_back({1'b0, a16} + {1'b0, b16} + {16'd0, cin16});
        left16 = 17;
      end
    end
  end

  // scoreboard: compares handshake and, on done, pops and compares the result
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      total++;
      if (busy8 !== (left8 != 0)) begin bad++; $display("FAIL sb_busy8 got=%b want=%b", busy8, left8 != 0); end
      total++;
      if (done8 !== (left8 == 1)) begin bad++; $display("FAIL sb_done8 got=%b want=%b", done8, left8 == 1); end
      if (!busy8 || done8) begin
        total++;
        if ({ba8, bb8, bc8} !== 3'b000) begin bad++; $display("FAIL sb_bits8 got=%b want=000", {ba8, bb8, bc8}); end
      end
      if (done8 && left8 == 1) begin
        total++;
        if (q8.size() == 0) begin bad++; $display("FAIL sb_empty8 got=empty want=entry"); end
        else begin
          e8 = q8.pop_front();
          if ({cout8, sum8} !== e8) begin bad++; $display("FAIL sb_res8 got=%h want=%h", {cout8, sum8}, e8); end
        end
      end
      total++;
      if (busy16 !== (left16 != 0)) begin bad++; $display("FAIL sb_busy16 got=%b want=%b", busy16, left16 != 0); end
      total++;
      if (done16 !== (left16 == 1)) begin bad++; $display("FAIL sb_done16 got=%b want=%b", done16, left16 == 1); end
      if (!busy16 || done16) begin
        total++;
        if ({ba16, bb16, bc16} !== 3'b000) begin bad++; $display("FAIL sb_bits16 got=%b want=000", {ba16, bb16, bc16}); end
      end
      if (done16 && left16 == 1) begin
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL sb_empty16 got=empty want=entry"); end
        else begin
          e16 = q16.pop_front();
          if ({cout16, sum16} !== e16) begin bad++; $display("FAIL sb_res16 got=%h want=%h", {cout16, sum16}, e16); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one 8-bit op, scrambles operands while running, returns in the done cycle or at the limit
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int lim, output int n);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < lim) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
      n++;
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input int lim, output int n);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    tick();
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < lim) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    repeat (2) tick();
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin bad++; $display("FAIL reset8 got=%h want=0", {busy8, done8, cout8, sum8}); end
    total++;
    if ({ba8, bb8, bc8} !== 3'b000) begin bad++; $display("FAIL reset_bits8 got=%b want=000", {ba8, bb8, bc8}); end
    total++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin bad++; $display("FAIL reset16 got=%h want=0", {busy16, done16, cout16, sum16}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int n;
    run8(8'h00, 8'h00, 1'b0, 30, n);
    total++;
    if (n !== 9) begin bad++; $display("FAIL zero_latency got=%0d want=9", n); end
    total++;
    if ({done8, cout8, sum8} !== 10'h200) begin bad++; $display("FAIL zero_result got=%h want=200", {done8, cout8, sum8}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int first = -1;
    int prev = -1;
    b8 = 8'h04; cin8 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      start8 = i <= 20;
      a8 = (i % 10 == 0) ? 8'h03 : 8'($urandom);
      b8 = (i % 10 == 0) ? 8'h04 : 8'($urandom);
      tick();
      if (done8) begin
        cnt++;
        total++;
        if ({cout8, sum8} !== 9'h007) begin bad++; $display("FAIL b2b_sum got=%h want=007", {cout8, sum8}); end
        if (prev >= 0) begin
          total++;
          if (i + 1 - prev !== 10) begin bad++; $display("FAIL b2b_gap got=%0d want=10", i + 1 - prev); end
        end
        if (first < 0) first = i + 1;
        prev = i + 1;
      end
    end
    total++;
    if (cnt !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", cnt); end
    total++;
    if (first !== 9) begin bad++; $display("FAIL b2b_first got=%0d want=9", first); end
  endtask

  task automatic test_carry();
    int n;
    run8(8'hFF, 8'h01, 1'b0, 30, n);
    total++;
    if ({done8, cout8, sum8} !== 10'h300) begin bad++; $display("FAIL carry_ff01 got=%h want=300", {done8, cout8, sum8}); end
    tick();
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy8, cout8, sum8} !== 10'h100) begin bad++; $display("FAIL carry_hold got=%h want=100", {busy8, cout8, sum8}); end
    run8(8'hA5, 8'h5A, 1'b1, 30, n);
    total++;
    if ({done8, cout8, sum8} !== 10'h300) begin bad++; $display("FAIL carry_a55a got=%h want=300", {done8, cout8, sum8}); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int n;
    int seen = 0;
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin bad++; $display("FAIL midrun_reset got=%h want=0", {busy8, done8, cout8, sum8}); end
    total++;
    if ({ba8, bb8, bc8} !== 3'b000) begin bad++; $display("FAIL midrun_bits got=%b want=000", {ba8, bb8, bc8}); end
    repeat (3) begin
      tick();
      if (done8 || busy8) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midrun_quiet got=%0d want=0", seen); end
    rst_n = 1'b1;
    run8(8'h10, 8'h20, 1'b0, 30, n);
    total++;
    if (n !== 9) begin bad++; $display("FAIL midrun_latency got=%0d want=9", n); end
    total++;
    if ({done8, cout8, sum8} !== 10'h230) begin bad++; $display("FAIL midrun_result got=%h want=230", {done8, cout8, sum8}); end
    tick();
  endtask

  task automatic test_random8();
    int n;
    logic [7:0] a, b;
    logic c;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
      run8(a, b, c, 20, n);
      total++;
      if ({done8, cout8, sum8} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL rand8 a=%h b=%h c=%b got=%h want=%h", a, b, c, {done8, cout8, sum8}, {1'b1, exp});
      end
      tick();
    end
  endtask

  task automatic test_random16();
    int n;
    logic [15:0] a, b;
    logic c;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
      run16(a, b, c, 30, n);
      total++;
      if ({done16, cout16, sum16} !== {1'b1, exp} || n !== 17) begin
        bad++;
        $display("FAIL rand16 a=%h b=%h c=%b cyc=%0d got=%h want=%h", a, b, c, n, {done16, cout16, sum16}, {1'b1, exp});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_carry();
    test_reset_midrun();
    test_random8();
    test_random16();
    repeat (2) tick();
    total++;
    if (q8.size() + q16.size() !== 0) begin bad++; $display("FAIL leftover got=%0d want=0", q8.size() + q16.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request new addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, sampled on accepted start.
REQ-006 b  input  WIDTH  operand B, sampled on accepted start.
REQ-007 cin  input  1  carry-in, sampled on accepted start.
REQ-008 bit_a  output  1  current A bit to downstream 1-bit adder stage.
REQ-009 bit_b  output  1  current B bit to 1-bit adder stage.
REQ-010 bit_ci  output  1  current carry to 1-bit adder stage.
REQ-011 bit_sum  input  1  sum bit returned by 1-bit adder (combinational from bit_a/b/ci).
REQ-012 bit_co  input  1  carry-out returned by 1-bit adder.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle pulse, result valid.
REQ-015 sum  output  WIDTH  result, LSB-first assembled.
REQ-016 cout  output  1  final carry-out.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE and start=1 at edge: latch a, b into shift registers, carry<=cin, bit counter<=0, clear sum shift register, go RUN.
REQ-019 IDLE and start=0: remain IDLE; sum/cout hold last result.
REQ-020 RUN: bit_a=A shift reg bit0, bit_b=B shift reg bit0, bit_ci=carry register, all driven combinationally from registers.
REQ-021 RUN each edge: shift bit_sum into sum register MSB (shift right), carry<=bit_co, shift A/B right by one, counter+1.
REQ-022 RUN with counter==WIDTH-1 at edge: perform REQ-021 capture, cout<=bit_co, go DONE.
REQ-023 DONE: done=1 for exactly that cycle, then IDLE unconditionally on next edge.
REQ-024 Latency: start sampled at edge k -> RUN cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1.
REQ-025 start while RUN or DONE SHALL be ignored; no queueing; operands of in-flight op unaffected.
REQ-026 start high in cycle after DONE (IDLE) SHALL be accepted; back-to-back throughput one op per WIDTH+2 cycles.
REQ-027 bit_a, bit_b, bit_ci SHALL be 0 in IDLE and DONE.
REQ-028 sum and cout SHALL be stable from DONE until next accepted start; sum SHALL equal (a+b+cin) mod 2^WIDTH, cout the bit WIDTH.
REQ-029 Counter width SHALL be $clog2(WIDTH)+1 bits; no wrap within an op.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, shift regs=0.
REQ-031 Reset mid-RUN SHALL abort the op with no done pulse; first edge after rst_n rises with start=1 SHALL be accepted.

Structure
REQ-032 Shared package SHALL hold the state enum type (IDLE/RUN/DONE) and default WIDTH constant.
REQ-033 No sub-module inside; the 1-bit adder is an external neighbour stage; bench SHALL instantiate a gate-level full-adder between bit_* ports.

Verification
REQ-034 WIDTH=8, a=0x00 b=0x00 cin=0 -> done in cycle k+9, sum=0x00 cout=0.
REQ-035 a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xA5 b=0x5A cin=1 -> sum=0x00 cout=1.
REQ-036 start held high for 20 cycles with a=0x03 b=0x04 -> ops accepted every 10 cycles, each sum=0x07, operand change during RUN ignored.
REQ-037 rst_n low at RUN cycle 4 -> all outputs 0, no done; new start a=0x10 b=0x20 -> sum=0x30 cout=0.
REQ-038 Random 1000 ops, WIDTH=8 and WIDTH=16 -> sum/cout match reference model; bit_* are 0 whenever busy=0 or done=1.
